// File: rtl/rgb_pwm_driver_if.sv
// Duty-value handshake between the fade generators (master) and the PWM stage (slave).
interface rgb_pwm_driver_if #(
  parameter int CHANNELS = 3,
  parameter int DW       = 11
);
  logic [CHANNELS-1:0][DW-1:0] duty_in;
  logic                        duty_valid;
  logic                        duty_ready;

  modport master (output duty_in, output duty_valid, input  duty_ready);
  modport slave  (input  duty_in, input  duty_valid, output duty_ready);
endinterface

// File: rtl/rgb_pwm_driver.sv
// Multi-channel LED PWM with a one-entry shadow duty buffer that commits only at period
// boundaries, plus optional per-channel phase stagger of the turn-on edges.
module rgb_pwm_lane #(
  parameter int PWM_INTERVAL = 1200,
  parameter int DW           = 11,
  parameter int OFF          = 0
) (
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] duty,
  output logic          on
);
  localparam logic [DW:0]   PI_W  = (DW+1)'(PWM_INTERVAL);
  localparam logic [DW+1:0] OFF_W = (DW+2)'(OFF);

  logic [DW+1:0] diff;
  logic [DW:0]   lc;

  // Borrow out of cnt-OFF selects the wrapped branch, so no modulo and no constant compare.
  always_comb begin
    diff = {2'b00, cnt} - OFF_W;
    lc   = diff[DW+1] ? (diff[DW:0] + PI_W) : diff[DW:0];
    on   = (lc < {1'b0, duty});
  end
endmodule

module rgb_pwm_driver #(
  parameter int PWM_INTERVAL  = 1200,
  parameter int CHANNELS      = 3,
  parameter int PHASE_STAGGER = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  rgb_pwm_driver_if.slave      dif,
  output logic [CHANNELS-1:0]  pwm_out,
  output logic                 period_start
);
  localparam int          DW       = $clog2(PWM_INTERVAL);
  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e                      state_q, state_d;
  logic [DW-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0][DW-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][DW-1:0] active_q, active_d;
  logic [CHANNELS-1:0]         pwm_q, pwm_d, on;
  logic                        ps_q, ps_d;
  logic                        commit;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    rgb_pwm_lane #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .DW           (DW),
      .OFF          ((PHASE_STAGGER != 0) ? i * (PWM_INTERVAL / CHANNELS) : 0)
    ) u_lane (
      .cnt  (cnt_q),
      .duty (active_q[i]),
      .on   (on[i])
    );
  end

  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != CNT_LAST)) cnt_d = cnt_q + DW'(1);
    // A disabled block commits immediately so a paused driver still picks up new duties.
    commit = !enable || (cnt_q == CNT_LAST);
    ps_d   = enable && (cnt_q == '0);
    pwm_d  = enable ? (on ^ {CHANNELS{POL}}) : {CHANNELS{POL}};
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      S_EMPTY: if (dif.duty_valid) begin
        shadow_d = dif.duty_in;
        state_d  = S_FULL;
      end
      S_FULL: if (commit) begin
        active_d = shadow_q;
        state_d  = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= {CHANNELS{POL}};
      ps_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      ps_q     <= ps_d;
    end
  end

  assign dif.duty_ready = (state_q == S_EMPTY);
  assign pwm_out        = pwm_q;
  assign period_start   = ps_q;
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench: two drivers (no stagger / stagger) share stimulus; waveforms are
// captured one period at a time and compared to hand-derived on-masks.
module tb_rgb_pwm_driver;
  localparam int PI = 12, CH = 3, DW = 4;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  always #5 clk = ~clk;

  rgb_pwm_driver_if #(.CHANNELS(CH), .DW(DW)) if0 ();
  rgb_pwm_driver_if #(.CHANNELS(CH), .DW(DW)) if1 ();
  logic [CH-1:0] pwm0, pwm1;
  logic          ps0, ps1;

  rgb_pwm_driver #(.PWM_INTERVAL(PI), .CHANNELS(CH), .PHASE_STAGGER(0), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dif(if0.slave), .pwm_out(pwm0), .period_start(ps0));
  rgb_pwm_driver #(.PWM_INTERVAL(PI), .CHANNELS(CH), .PHASE_STAGGER(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dif(if1.slave), .pwm_out(pwm1), .period_start(ps1));

  // d = {b,g,r}; w0/w1 = per-channel on-mask, bit k = cycle k after period_start rises
  typedef struct packed {
    logic [2:0][3:0]  d;
    logic [2:0][11:0] w0;
    logic [2:0][11:0] w1;
  } vec_t;

  vec_t vecs [5];
  int total = 0, bad = 0;
  logic [2:0][11:0] w0, w1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  task automatic drive(input logic [2:0][3:0] d, input logic v);
    if0.duty_in = d; if1.duty_in = d;
    if0.duty_valid = v; if1.duty_valid = v;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!if0.duty_ready && n < 100) begin tick(); n++; end
    if (!if0.duty_ready) timeout(nm);
  endtask

  task automatic load(input logic [2:0][3:0] d);
    wait_ready("load_ready");
    drive(d, 1'b1);
    tick();
    drive(d, 1'b0);
  endtask

  task automatic wait_ps(input string nm);
    int n = 0;
    while (!ps0 && n < 40) begin tick(); n++; end
    if (!ps0) timeout(nm);
  endtask

  task automatic collect();
    for (int k = 0; k < PI; k++) begin
      for (int c = 0; c < CH; c++) begin
        w0[c][k] = ~pwm0[c];
        w1[c][k] = ~pwm1[c];
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0].d = {4'd12, 4'd6, 4'd3};
    vecs[0].w0 = {12'hFFF, 12'h03F, 12'h007}; vecs[0].w1 = {12'hFFF, 12'h3F0, 12'h007};
    vecs[1].d = {4'd4, 4'd4, 4'd4};
    vecs[1].w0 = {12'h00F, 12'h00F, 12'h00F}; vecs[1].w1 = {12'hF00, 12'h0F0, 12'h00F};
    vecs[2].d = {4'd11, 4'd0, 4'd15};
    vecs[2].w0 = {12'h7FF, 12'h000, 12'hFFF}; vecs[2].w1 = {12'hF7F, 12'h000, 12'hFFF};
    vecs[3].d = {4'd7, 4'd11, 4'd1};
    vecs[3].w0 = {12'h07F, 12'h7FF, 12'h001}; vecs[3].w1 = {12'hF07, 12'hFF7, 12'h001};
    vecs[4].d = {4'd0, 4'd0, 4'd0};
    vecs[4].w0 = '0; vecs[4].w1 = '0;

    drive('0, 1'b0);
    tick(); tick();
    chk("rst_pwm0", pwm0, 3'b111);
    chk("rst_pwm1", pwm1, 3'b111);
    chk("rst_ps", ps0, 1'b0);
    rst_n = 1'b1;
    chk("rst_ready0", if0.duty_ready, 1'b1);
    chk("rst_ready1", if1.duty_ready, 1'b1);
    enable = 1'b1;

    for (int i = 0; i < 5; i++) begin
      load(vecs[i].d);
      wait_ready("commit");
      wait_ps("vec_ps");
      collect();
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("v%0d_ch%0d_flat", i, c), w0[c], vecs[i].w0[c]);
        chk($sformatf("v%0d_ch%0d_stag", i, c), w1[c], vecs[i].w1[c]);
      end
    end

    // A then B back to back: B waits for A's commit, A rules exactly one period
    load({4'd2, 4'd2, 4'd2});
    chk("a_full_not_ready", if0.duty_ready, 1'b0);
    drive({4'd5, 4'd5, 4'd5}, 1'b1);
    begin
      int n = 0;
      while (!if0.duty_ready && n < 40) begin tick(); n++; end
      if (!if0.duty_ready) timeout("a_commit");
    end
    chk("a_commit_ps_low", ps0, 1'b0);
    tick();
    drive({4'd5, 4'd5, 4'd5}, 1'b0);
    chk("b_accepted", if0.duty_ready, 1'b0);
    chk("a_period_ps", ps0, 1'b1);
    collect();
    chk("a_period_r", w0[0], 12'h003);
    chk("b_period_ps", ps0, 1'b1);
    chk("b_committed_ready", if0.duty_ready, 1'b1);
    collect();
    chk("b_period_r", w0[0], 12'h01F);

    // Drop enable at cnt=5, duty must survive the pause
    wait_ps("drop_ps");
    repeat (4) tick();
    chk("pre_drop_pwm0", pwm0, 3'b000);
    enable = 1'b0;
    tick();
    chk("drop_pwm0", pwm0, 3'b111);
    chk("drop_pwm1", pwm1, 3'b111);
    chk("drop_ps", ps0, 1'b0);
    tick();
    enable = 1'b1;
    tick();
    chk("reen_ps", ps0, 1'b1);
    chk("reen_pwm0", pwm0, 3'b000);
    collect();
    chk("kept_duty_r", w0[0], 12'h01F);

    // Loads while disabled commit on the next cycle
    enable = 1'b0;
    tick();
    drive({4'd12, 4'd6, 4'd3}, 1'b1);
    tick();
    drive({4'd12, 4'd6, 4'd3}, 1'b0);
    chk("dis_accept", if0.duty_ready, 1'b0);
    tick();
    chk("dis_commit", if0.duty_ready, 1'b1);
    chk("dis_pwm1", pwm1, 3'b111);
    enable = 1'b1;
    tick();
    chk("dis_reen_ps", ps0, 1'b1);
    collect();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("dis_ch%0d_flat", c), w0[c], vecs[0].w0[c]);
      chk($sformatf("dis_ch%0d_stag", c), w1[c], vecs[0].w1[c]);
    end

    // Asynchronous reset mid-period with the shadow full
    load({4'd1, 4'd1, 4'd1});
    chk("pre_rst_b_on", pwm0[2], 1'b0);
    chk("pre_rst_full", if0.duty_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm0", pwm0, 3'b111);
    chk("arst_pwm1", pwm1, 3'b111);
    chk("arst_ps", ps0, 1'b0);
    chk("arst_ready", if0.duty_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    wait_ps("post_rst_ps");
    collect();
    chk("post_rst_flat", w0, 36'h0);
    chk("post_rst_stag", w1, 36'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
